// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two requesters share one single-port memory through
// valid/ready handshakes. At most one transfer is accepted per cycle. A
// transfer is either a write or a read, and read data comes back one cycle
// after the read is accepted.
// Optional feature macro: MEM_ARB_FIXED_PRIORITY_EN. When it is defined,
// requester 0 always wins. When it is undefined, the arbiter is round-robin.
module mem_port_arbiter #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_write,
  input  logic [2*ADDR_BITS-1:0] req_addr,
  input  logic [2*DATA_BITS-1:0] req_wdata,
  output logic [1:0]             resp_valid,
  output logic [DATA_BITS-1:0]   resp_rdata,
  output logic [31:0]            grant_cnt0,
  output logic [31:0]            grant_cnt1
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [1:0]           grant;
  logic                 xfer;
  logic                 sel;
  logic                 sel_write;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  logic [1:0]           resp_valid_reg;
  logic [DATA_BITS-1:0] rdata_reg;
  logic [31:0]          cnt_reg [2];

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: requester 1 is granted only when requester 0 is idle.
  always_comb begin
    grant = 2'b00;
    if (req_valid[0])      grant = 2'b01;
    else if (req_valid[1]) grant = 2'b10;
  end
`else
  logic last_reg;

  // Last-grant pointer. Its reset value is 1 so that requester 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (!reset_n)  last_reg <= 1'b1;
    else if (xfer) last_reg <= sel;
  end

  // Round-robin: a lone requester wins; under contention the other one from last time wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
`endif

  // Nothing is accepted while reset is held, even though the grant logic is combinational.
  assign req_ready = grant & {2{reset_n}};
  assign xfer      = |req_ready;
  assign sel       = req_ready[1];
  assign sel_write = sel ? req_write[1] : req_write[0];
  assign sel_addr  = sel ? req_addr[2*ADDR_BITS-1:ADDR_BITS] : req_addr[ADDR_BITS-1:0];
  assign sel_wdata = sel ? req_wdata[2*DATA_BITS-1:DATA_BITS] : req_wdata[DATA_BITS-1:0];

  // Memory array write port. The contents are not reset, so this infers block RAM.
  always_ff @(posedge clock) begin
    if (xfer && sel_write) mem[sel_addr] <= sel_wdata;
  end

  // Registered read data and the per-requester response flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resp_valid_reg <= 2'b00;
      rdata_reg      <= '0;
    end else begin
      resp_valid_reg <= req_ready & ~req_write;
      if (xfer && !sel_write) rdata_reg <= mem[sel_addr];
    end
  end

  // Gate the output with reset_n. A read accepted just before reset must not
  // show a response while reset_n is low.
  assign resp_valid = resp_valid_reg & {2{reset_n}};
  assign resp_rdata = rdata_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Count the accepted transfers of this requester. The count wraps modulo 2^32.
      always_ff @(posedge clock) begin
        if (!reset_n)           cnt_reg[gi] <= 32'd0;
        else if (req_ready[gi]) cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
      end
    end
  endgenerate

  assign grant_cnt0 = cnt_reg[0];
  assign grant_cnt1 = cnt_reg[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the stimulus pushes expected read
// responses, and the monitor pops and compares them when they fall due.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  resp_valid;
  logic [15:0] resp_rdata;
  logic [31:0] grant_cnt0;
  logic [31:0] grant_cnt1;

  mem_port_arbiter #(.ADDR_BITS(5), .DATA_BITS(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] data;
    int          due;
  } resp_t;

  resp_t       exp_q[$];
  logic [15:0] mem_model [32];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          suppress_push = 1'b0;

  always @(posedge clock) cyc++;

  // The monitor compares every due response and flags any response that was not expected.
  always @(negedge clock) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      resp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (resp_valid !== e.valid || resp_rdata !== e.data) begin
        n_fail++;
        $display("FAIL resp cyc=%0d: got valid=%b data=%h, required valid=%b data=%h",
                 cyc, resp_valid, resp_rdata, e.valid, e.data);
      end else
        $display("resp cyc=%0d valid=%b data=%h ok", cyc, resp_valid, resp_rdata);
    end else if (resp_valid !== 2'b00) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_resp cyc=%0d: got valid=%b, required 00", cyc, resp_valid);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else
      $display("%s = %h ok", name, act);
  endtask

  // Called at posedge+1. Drives one cycle, checks req_ready at negedge and
  // records the expected effect of the transfer that the bench predicts.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] exp_rdy, input string tag);
    logic [4:0]  a [2];
    logic [15:0] d [2];
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(negedge clock);
    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: req_ready got %b, required %b", tag, cyc, req_ready, exp_rdy);
    end else
      $display("%s cyc=%0d req_ready=%b ok", tag, cyc, req_ready);
    for (int i = 0; i < 2; i++) begin
      if (exp_rdy[i]) begin
        if (w[i]) mem_model[a[i]] = d[i];
        else if (!suppress_push) begin
          resp_t e;
          e.valid = (i == 0) ? 2'b01 : 2'b10;
          e.data  = mem_model[a[i]];
          e.due   = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 5'd0, 5'd0, 16'h0, 16'h0, 2'b00, "idle");
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    @(negedge clock);
    chk("ready_in_reset", {30'd0, req_ready}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("resp_valid_reset", {30'd0, resp_valid}, 32'd0);
    chk("resp_rdata_reset", {16'd0, resp_rdata}, 32'd0);
    chk("cnt0_reset", grant_cnt0, 32'd0);
    chk("cnt1_reset", grant_cnt1, 32'd0);
    req_valid = 2'b00;
    reset_n   = 1'b1;
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  initial begin
    logic [1:0]  exp;
    logic [1:0]  pw;
    logic [4:0]  pa [2];
    logic [15:0] pd [2];
    logic [31:0] rs;
    int          g;
    int          diff;
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clock); #1;
    do_reset();

    // Preload every address through requester 0.
    for (int i = 0; i < 32; i++)
      step(2'b01, 2'b01, 5'(i), 5'd0, 16'h1000 + 16'(i * 7), 16'h0, 2'b01, "preload");
    idle();

    // Both requesters read continuously for 4 cycles.
    do_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      exp = 2'b01;
`else
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      step(2'b11, 2'b00, 5'd0, 5'd1, 16'h0, 16'h0, exp, "contend");
    end
    idle();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    chk("contend_cnt0", grant_cnt0, 32'd4);
    chk("contend_cnt1", grant_cnt1, 32'd0);
`else
    chk("contend_cnt0", grant_cnt0, 32'd2);
    chk("contend_cnt1", grant_cnt1, 32'd2);
`endif

    // Only requester 1 is valid, for 5 cycles.
    do_reset();
    for (int k = 0; k < 5; k++)
      step(2'b10, 2'b00, 5'd0, 5'd5, 16'h0, 16'h0, 2'b10, "solo1");
    idle();
    chk("solo1_cnt0", grant_cnt0, 32'd0);
    chk("solo1_cnt1", grant_cnt1, 32'd5);

    // Requester 0 writes, then requester 1 reads the same address on the next cycle.
    step(2'b01, 2'b01, 5'd3, 5'd0, 16'hBEEF, 16'h0, 2'b01, "wr_beef");
    step(2'b10, 2'b00, 5'd0, 5'd3, 16'h0, 16'h0, 2'b10, "rd_beef");
    idle();

    // A read accepted just before reset must produce no response.
    suppress_push = 1'b1;
    step(2'b01, 2'b00, 5'd2, 5'd0, 16'h0, 16'h0, 2'b01, "rd_then_reset");
    suppress_push = 1'b0;
    reset_n   = 1'b0;
    req_valid = 2'b00;
    @(negedge clock);
    chk("suppressed_resp", {30'd0, resp_valid}, 32'd0);
    @(posedge clock); #1;
    chk("cnt0_after_rst", grant_cnt0, 32'd0);
    chk("cnt1_after_rst", grant_cnt1, 32'd0);
    reset_n = 1'b1;

    // Random payloads from XorShift while both requesters stay valid. A requester
    // gets a new payload only after it has been accepted.
    do_reset();
    rs = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      rs = xs(rs); pw[i] = rs[0]; pa[i] = rs[5:1]; pd[i] = rs[31:16];
    end
    for (int k = 0; k < 400; k++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      exp = 2'b01;
`else
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      step(2'b11, pw, pa[0], pa[1], pd[0], pd[1], exp, "rand");
      g = exp[1] ? 1 : 0;
      rs = xs(rs); pw[g] = rs[0]; pa[g] = rs[5:1]; pd[g] = rs[31:16];
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      diff = int'(grant_cnt0) - int'(grant_cnt1);
      n_checks++;
      if (diff < -1 || diff > 1) begin
        n_fail++;
        $display("FAIL fairness k=%0d: cnt0=%0d cnt1=%0d, required |diff|<=1", k, grant_cnt0, grant_cnt1);
      end
`endif
    end
    idle();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    chk("rand_cnt0", grant_cnt0, 32'd400);
    chk("rand_cnt1", grant_cnt1, 32'd0);
`else
    chk("rand_cnt0", grant_cnt0, 32'd200);
    chk("rand_cnt1", grant_cnt1, 32'd200);
`endif
    idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
